// File: rtl/int_stim_pkg.sv
// Shared types and constants for the multi-channel interrupt stimulus controller.
package int_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ASSERT   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } chan_state_t;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7f20;
  localparam logic [31:0] PC_WORD_MASK     = 32'hffff_fffc;

endpackage

// File: rtl/int_stim_chan.sv
// One interrupt channel: FSM, fire budget, edge-qualified PC match and acknowledge timer.
module int_stim_chan
  import int_stim_pkg::*;
#(
  parameter int               CNT_W   = 4,
  parameter int               TMO_W   = 12,
  parameter logic [TMO_W-1:0] TMO_MAX = 12'd2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_w,
  input  logic             cfg_sel,
  input  logic [31:0]      cfg_pc,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic             cfg_pulse,
  input  logic             ack_clr,
  output logic             pending,
  output logic             irq,
  output logic             tmo_hit
);

  chan_state_t      state_reg, state_next;
  logic [31:0]      trig_pc_reg;
  logic [CNT_W-1:0] budget_reg;
  logic             pulse_reg;
  logic             rearm_ok_reg;
  logic [TMO_W-1:0] timer_reg;

  logic match;
  logic fire;
  logic unlimited;

  assign match     = (pc_w == trig_pc_reg);
  assign fire      = (state_reg == ST_ARMED) && match && rearm_ok_reg;
  assign unlimited = &budget_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_sel) begin
      state_next = (cfg_cnt != '0) ? ST_ARMED : ST_IDLE;
    end else begin
      case (state_reg)
        ST_ARMED: begin
          if (fire) state_next = ST_ASSERT;
        end
        ST_ASSERT: begin
          if (ack_clr)        state_next = (budget_reg != '0) ? ST_ARMED : ST_DONE;
          else if (pulse_reg) state_next = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_clr) state_next = (budget_reg != '0) ? ST_ARMED : ST_DONE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    pending = (state_reg == ST_ASSERT) || (state_reg == ST_WAIT_ACK);
    irq     = (state_reg == ST_ASSERT);
    tmo_hit = pending && (timer_reg == TMO_MAX);
  end

  // After an ack the channel may only re-fire once the PC has left the trigger word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trig_pc_reg  <= '0;
      budget_reg   <= '0;
      pulse_reg    <= 1'b0;
      rearm_ok_reg <= 1'b0;
      timer_reg    <= '0;
    end else if (cfg_sel) begin
      trig_pc_reg  <= cfg_pc & PC_WORD_MASK;
      budget_reg   <= cfg_cnt;
      pulse_reg    <= cfg_pulse;
      rearm_ok_reg <= 1'b1;
      timer_reg    <= '0;
    end else begin
      if (fire) begin
        timer_reg <= '0;
        if (!unlimited) budget_reg <= budget_reg - CNT_W'(1);
      end else if (pending && (timer_reg != TMO_MAX)) begin
        timer_reg <= timer_reg + TMO_W'(1);
      end

      if (pending && ack_clr) rearm_ok_reg <= 1'b0;
      else if (!match)        rearm_ok_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/int_stim_ctrl.sv
// Multi-channel PC-triggered interrupt stimulus controller: config decode, ack priority, IRQ merge.
module int_stim_ctrl
  import int_stim_pkg::*;
#(
  parameter int               N_CH     = 4,
  parameter int               CNT_W    = 4,
  parameter logic [31:0]      ACK_ADDR = ACK_ADDR_DEFAULT,
  parameter int               TMO_W    = 12,
  parameter logic [TMO_W-1:0] TMO_MAX  = 12'd2000,
  localparam int              CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      macroscopic_pc,
  input  logic [31:0]      m_int_addr,
  input  logic [3:0]       m_int_byteen,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [31:0]      cfg_pc,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic             cfg_pulse,
  output logic             interrupt,
  output logic [N_CH-1:0]  irq_vec,
  output logic [CH_W-1:0]  ack_ch,
  output logic             tmo_err
);

  logic [31:0]     pc_w;
  logic            ack;
  logic            ack_hit;
  logic [CH_W-1:0] ack_idx;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] tmo_hit;
  logic [N_CH-1:0] cfg_sel;
  logic [N_CH-1:0] ack_clr;
  logic [CH_W-1:0] ack_ch_reg;
  logic            tmo_err_reg;

  assign pc_w    = macroscopic_pc & PC_WORD_MASK;
  assign ack     = (|m_int_byteen) && ((m_int_addr & PC_WORD_MASK) == ACK_ADDR);
  assign ack_hit = ack && (|pending);

  // Descending scan so the lowest pending index is the one left standing.
  always_comb begin
    ack_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) ack_idx = CH_W'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign cfg_sel[gi] = cfg_we && (cfg_ch == CH_W'(gi));
      assign ack_clr[gi] = ack_hit && (ack_idx == CH_W'(gi));

      int_stim_chan #(
        .CNT_W   (CNT_W),
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .pc_w      (pc_w),
        .cfg_sel   (cfg_sel[gi]),
        .cfg_pc    (cfg_pc),
        .cfg_cnt   (cfg_cnt),
        .cfg_pulse (cfg_pulse),
        .ack_clr   (ack_clr[gi]),
        .pending   (pending[gi]),
        .irq       (irq_vec[gi]),
        .tmo_hit   (tmo_hit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_ch_reg  <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      if (ack_hit)    ack_ch_reg  <= ack_idx;
      if (|tmo_hit)   tmo_err_reg <= 1'b1;
    end
  end

  assign ack_ch    = ack_ch_reg;
  assign tmo_err   = tmo_err_reg;
  assign interrupt = |irq_vec;

endmodule

// File: tb/tb_int_stim_ctrl.sv
// Directed bench for int_stim_ctrl: legacy one-shot, budgets, pulse, arbitration, timeout, reset.
module tb_int_stim_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_pc;
  logic [3:0]  cfg_cnt;
  logic        cfg_pulse;
  logic        interrupt;
  logic [3:0]  irq_vec;
  logic [1:0]  ack_ch;
  logic        tmo_err;

  int checks = 0;
  int errors = 0;

  int_stim_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_pc         (cfg_pc),
    .cfg_cnt        (cfg_cnt),
    .cfg_pulse      (cfg_pulse),
    .interrupt      (interrupt),
    .irq_vec        (irq_vec),
    .ack_ch         (ack_ch),
    .tmo_err        (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [31:0] pc, input logic [3:0] cnt, input logic pulse);
    cfg_we = 1'b1; cfg_ch = ch; cfg_pc = pc; cfg_cnt = cnt; cfg_pulse = pulse;
    tick(1);
    cfg_we = 1'b0;
    $display("cfg ch=%0d pc=%08h cnt=%0h pulse=%0b -> irq_vec=%04b", ch, pc, cnt, pulse, irq_vec);
  endtask

  task automatic do_ack(input logic [31:0] pc);
    macroscopic_pc = pc; m_int_addr = 32'h0000_7f22; m_int_byteen = 4'b0011;
    tick(1);
    m_int_byteen = 4'b0000; m_int_addr = 32'h0;
    $display("ack -> ack_ch=%0d irq_vec=%04b", ack_ch, irq_vec);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    macroscopic_pc = 32'h0; m_int_addr = 32'h0; m_int_byteen = 4'b0;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_pc = 32'h0; cfg_cnt = 4'h0; cfg_pulse = 1'b0;
    tick(3);
    checks++;
    if ({interrupt, irq_vec, ack_ch, tmo_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got int=%0b irq=%04b ack_ch=%0d tmo=%0b required all 0",
               interrupt, irq_vec, ack_ch, tmo_err);
    end
    reset = 1'b1;
    tick(1);
    $display("reset released");
  endtask

  task automatic test_legacy;
    cfg(2'd0, 32'h3010, 4'd1, 1'b0);
    macroscopic_pc = 32'h3010;
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL legacy_early: got %0b required 0", interrupt);
    end
    tick(1);
    checks++;
    if (interrupt !== 1'b1 || irq_vec !== 4'b0001) begin
      errors++; $display("FAIL legacy_fire: got int=%0b irq=%04b required 1/0001", interrupt, irq_vec);
    end
    do_ack(32'h3014);
    checks++;
    if (interrupt !== 1'b0 || ack_ch !== 2'd0) begin
      errors++; $display("FAIL legacy_ack: got int=%0b ack_ch=%0d required 0/0", interrupt, ack_ch);
    end
    tick(1);
    macroscopic_pc = 32'h3010;
    tick(2);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL legacy_done: got %0b required 0", interrupt);
    end
    macroscopic_pc = 32'h3000;
    tick(1);
  endtask

  task automatic test_budget;
    int fires1 = 0;
    int fires2 = 0;
    cfg(2'd1, 32'h3100, 4'd3, 1'b0);
    cfg(2'd2, 32'h3200, 4'hf, 1'b0);
    for (int p = 0; p < 5; p++) begin
      macroscopic_pc = 32'h3100;
      tick(1);
      if (irq_vec[1]) fires1++;
      do_ack(32'h3000);
      tick(1);
      macroscopic_pc = 32'h3200;
      tick(1);
      if (irq_vec[2]) fires2++;
      do_ack(32'h3000);
      tick(1);
    end
    checks++;
    if (fires1 != 3) begin
      errors++; $display("FAIL budget_ch1: got %0d fires required 3", fires1);
    end
    checks++;
    if (fires2 != 5) begin
      errors++; $display("FAIL budget_unlimited_ch2: got %0d fires required 5", fires2);
    end
    checks++;
    if (ack_ch !== 2'd2) begin
      errors++; $display("FAIL budget_ack_ch: got %0d required 2", ack_ch);
    end
  endtask

  task automatic test_pulse;
    cfg(2'd0, 32'h3300, 4'hf, 1'b1);
    macroscopic_pc = 32'h3300;
    tick(1);
    checks++;
    if (irq_vec[0] !== 1'b1) begin
      errors++; $display("FAIL pulse_high: got %0b required 1", irq_vec[0]);
    end
    tick(1);
    checks++;
    if (irq_vec[0] !== 1'b0) begin
      errors++; $display("FAIL pulse_one_cycle: got %0b required 0", irq_vec[0]);
    end
    macroscopic_pc = 32'h3000;
    tick(1);
    macroscopic_pc = 32'h3300;
    tick(2);
    checks++;
    if (irq_vec !== 4'b0000) begin
      errors++; $display("FAIL pulse_no_refire: got %04b required 0000", irq_vec);
    end
    do_ack(32'h3000);
    checks++;
    if (ack_ch !== 2'd0) begin
      errors++; $display("FAIL pulse_ack_ch: got %0d required 0", ack_ch);
    end
    tick(1);
    macroscopic_pc = 32'h3300;
    tick(1);
    checks++;
    if (irq_vec !== 4'b0001) begin
      errors++; $display("FAIL pulse_refire: got %04b required 0001", irq_vec);
    end
    do_ack(32'h3000);
    cfg(2'd0, 32'h0, 4'd0, 1'b0);
    cfg(2'd2, 32'h0, 4'd0, 1'b0);
  endtask

  task automatic test_arbitration;
    cfg(2'd1, 32'h3400, 4'd1, 1'b0);
    cfg(2'd3, 32'h3404, 4'd1, 1'b0);
    macroscopic_pc = 32'h3400;
    tick(1);
    macroscopic_pc = 32'h3404;
    tick(1);
    checks++;
    if (irq_vec !== 4'b1010) begin
      errors++; $display("FAIL arb_pending: got %04b required 1010", irq_vec);
    end
    do_ack(32'h3500);
    checks++;
    if (ack_ch !== 2'd1 || irq_vec !== 4'b1000) begin
      errors++; $display("FAIL arb_first: got ack_ch=%0d irq=%04b required 1/1000", ack_ch, irq_vec);
    end
    do_ack(32'h3500);
    checks++;
    if (ack_ch !== 2'd3 || irq_vec !== 4'b0000) begin
      errors++; $display("FAIL arb_second: got ack_ch=%0d irq=%04b required 3/0000", ack_ch, irq_vec);
    end
    do_ack(32'h3500);
    checks++;
    if (ack_ch !== 2'd3 || irq_vec !== 4'b0000 || interrupt !== 1'b0) begin
      errors++; $display("FAIL arb_spurious: got ack_ch=%0d irq=%04b required 3/0000", ack_ch, irq_vec);
    end
  endtask

  task automatic test_back_to_back;
    cfg(2'd1, 32'h3600, 4'hf, 1'b0);
    cfg(2'd3, 32'h3604, 4'hf, 1'b0);
    macroscopic_pc = 32'h3600;
    tick(1);
    do_ack(32'h3604);
    checks++;
    if (irq_vec !== 4'b1000 || ack_ch !== 2'd1) begin
      errors++; $display("FAIL b2b_ack_and_match: got irq=%04b ack_ch=%0d required 1000/1", irq_vec, ack_ch);
    end
    do_ack(32'h3500);
    tick(1);
    macroscopic_pc = 32'h3600;
    tick(1);
    checks++;
    if (irq_vec !== 4'b0010) begin
      errors++; $display("FAIL b2b_fire: got %04b required 0010", irq_vec);
    end
    do_ack(32'h3600);
    tick(2);
    checks++;
    if (irq_vec !== 4'b0000) begin
      errors++; $display("FAIL b2b_edge_suppress: got %04b required 0000", irq_vec);
    end
    macroscopic_pc = 32'h3500;
    tick(1);
    macroscopic_pc = 32'h3600;
    tick(1);
    checks++;
    if (irq_vec !== 4'b0010) begin
      errors++; $display("FAIL b2b_edge_refire: got %04b required 0010", irq_vec);
    end
    macroscopic_pc = 32'h3500;
    cfg(2'd1, 32'h0, 4'd0, 1'b0);
    checks++;
    if (irq_vec !== 4'b0000) begin
      errors++; $display("FAIL b2b_cfg_override: got %04b required 0000", irq_vec);
    end
    cfg(2'd3, 32'h0, 4'd0, 1'b0);
  endtask

  task automatic test_timeout;
    cfg(2'd2, 32'h3700, 4'd1, 1'b0);
    macroscopic_pc = 32'h3700;
    tick(1);
    macroscopic_pc = 32'h3800;
    tick(1900);
    checks++;
    if (tmo_err !== 1'b0 || irq_vec !== 4'b0100) begin
      errors++; $display("FAIL tmo_early: got tmo=%0b irq=%04b required 0/0100", tmo_err, irq_vec);
    end
    tick(105);
    checks++;
    if (tmo_err !== 1'b1 || irq_vec !== 4'b0100) begin
      errors++; $display("FAIL tmo_set: got tmo=%0b irq=%04b required 1/0100", tmo_err, irq_vec);
    end
    cfg(2'd2, 32'h0, 4'd0, 1'b0);
    checks++;
    if (irq_vec[2] !== 1'b0 || tmo_err !== 1'b1) begin
      errors++; $display("FAIL tmo_reconfig: got irq2=%0b tmo=%0b required 0/1", irq_vec[2], tmo_err);
    end
    tick(5);
    checks++;
    if (tmo_err !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: got %0b required 1", tmo_err);
    end
  endtask

  task automatic test_reset_mid_irq;
    cfg(2'd0, 32'h3900, 4'hf, 1'b0);
    macroscopic_pc = 32'h3900;
    tick(1);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL rst_pre_fire: got %0b required 1", interrupt);
    end
    reset = 1'b0;
    tick(1);
    checks++;
    if ({interrupt, irq_vec, ack_ch, tmo_err} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_irq: got int=%0b irq=%04b ack_ch=%0d tmo=%0b required all 0",
               interrupt, irq_vec, ack_ch, tmo_err);
    end
    reset = 1'b1;
    macroscopic_pc = 32'h3800;
    tick(1);
    macroscopic_pc = 32'h3900;
    tick(3);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL rst_no_fire: got %0b required 0", interrupt);
    end
    cfg(2'd0, 32'h3900, 4'd1, 1'b0);
    tick(1);
    checks++;
    if (interrupt !== 1'b1 || irq_vec !== 4'b0001) begin
      errors++; $display("FAIL rst_reconfig_fire: got int=%0b irq=%04b required 1/0001", interrupt, irq_vec);
    end
  endtask

  initial begin
    test_reset;
    test_legacy;
    test_budget;
    test_pulse;
    test_arbitration;
    test_back_to_back;
    test_timeout;
    test_reset_mid_irq;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
